// File: rtl/bitsim_ctrl_pkg.sv
// Shared control types and helpers for the bit-serial MAC sequencer.
package bitsim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  // Callers zero-extend their mask to this width before calling.
  localparam int ENC_MAX_WIDTH = 64;

  function automatic int lowest_set_bit(input logic [ENC_MAX_WIDTH-1:0] v);
    lowest_set_bit = 0;
    for (int i = ENC_MAX_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_bit = i;
    end
  endfunction

endpackage

// File: rtl/bit_serial_mac_seq_if.sv
// Operand-in / result-out handshake bundle for the bit-serial MAC sequencer.
interface bit_serial_mac_seq_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH,
  parameter int CNT_WIDTH    = $clog2(WEIGHT_WIDTH + 1)
);

  logic                           in_valid;
  logic                           in_ready;
  logic signed [DATA_WIDTH-1:0]   act;
  logic signed [WEIGHT_WIDTH-1:0] weight;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [ACC_WIDTH-1:0]    out_result;
  logic [CNT_WIDTH-1:0]           out_cycles;
  logic                           busy;

  modport master (
    output in_valid, act, weight, out_ready,
    input  in_ready, out_valid, out_result, out_cycles, busy
  );

  modport slave (
    input  in_valid, act, weight, out_ready,
    output in_ready, out_valid, out_result, out_cycles, busy
  );

endinterface

// File: rtl/pos_neg_select.sv
// Passes the activation through or negates it, one bit wider so that the
// most negative activation negates without overflow.
module pos_neg_select #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] value,
  input  logic                         sign,
  output logic signed [DATA_WIDTH:0]   result
);

  logic signed [DATA_WIDTH:0] ext;

  assign ext    = {value[DATA_WIDTH-1], value};
  assign result = sign ? -ext : ext;

endmodule

// File: rtl/bit_serial_mac_seq.sv
// Bit-serial signed multiplier: one weight bit-plane per RUN cycle, the MSB
// plane subtracted; optionally skips zero weight bits.
module bit_serial_mac_seq
  import bitsim_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = DATA_WIDTH + WEIGHT_WIDTH,
  parameter int SKIP_ZERO    = 1,
  parameter int CNT_WIDTH    = $clog2(WEIGHT_WIDTH + 1)
) (
  input logic                clk,
  input logic                rst_n,
  bit_serial_mac_seq_if.slave bus
);

  localparam int IDX_W = (WEIGHT_WIDTH > 1) ? $clog2(WEIGHT_WIDTH) : 1;

  seq_state_e                     state;
  logic signed [DATA_WIDTH-1:0]   act_r;
  logic [WEIGHT_WIDTH-1:0]        mask;
  logic [IDX_W-1:0]               bit_idx;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic [CNT_WIDTH-1:0]           count;

  logic [IDX_W-1:0]               enc_b;
  logic [IDX_W-1:0]               b;
  logic                           msb_plane;
  logic                           last_plane;
  logic signed [DATA_WIDTH:0]     sel_term;
  logic signed [ACC_WIDTH-1:0]    term_ext;
  logic signed [ACC_WIDTH-1:0]    term;

  // Plane selection: lowest remaining set bit when skipping, else a plain counter.
  assign enc_b     = IDX_W'(lowest_set_bit(ENC_MAX_WIDTH'(mask)));
  assign b         = (SKIP_ZERO != 0) ? enc_b : bit_idx;
  assign msb_plane = (b == IDX_W'(WEIGHT_WIDTH - 1));

  pos_neg_select #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pos_neg_select (
    .value (act_r),
    .sign  (msb_plane),
    .result(sel_term)
  );

  assign term_ext = {{(ACC_WIDTH - DATA_WIDTH - 1){sel_term[DATA_WIDTH]}}, sel_term};
  assign term     = mask[b] ? (term_ext << b) : '0;

  assign last_plane = (SKIP_ZERO != 0)
                    ? ((mask & (mask - WEIGHT_WIDTH'(1))) == '0)
                    : msb_plane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      act_r   <= '0;
      mask    <= '0;
      bit_idx <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            act_r   <= bus.act;
            mask    <= bus.weight;
            acc     <= '0;
            count   <= '0;
            bit_idx <= '0;
            state   <= ((SKIP_ZERO != 0) && (bus.weight == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          acc     <= acc + term;
          mask    <= mask & ~(WEIGHT_WIDTH'(1) << b);
          count   <= count + CNT_WIDTH'(1);
          bit_idx <= bit_idx + IDX_W'(1);
          if (last_plane) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_result = acc;
  assign bus.out_cycles = count;

endmodule

// File: tb/tb_bit_serial_mac_seq.sv
// Directed bench for bit_serial_mac_seq with SKIP_ZERO=1 and SKIP_ZERO=0 instances.
module tb_bit_serial_mac_seq;

  logic clk;
  logic rst_n;
  int   nTests;
  int   nFail;

  bit_serial_mac_seq_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8)) if_sz ();
  bit_serial_mac_seq_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8)) if_nz ();

  bit_serial_mac_seq #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SKIP_ZERO(1)) dut_sz (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_sz)
  );

  bit_serial_mac_seq #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SKIP_ZERO(0)) dut_nz (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [31:0] getValid(input bit nz);
    return nz ? {31'd0, if_nz.out_valid} : {31'd0, if_sz.out_valid};
  endfunction

  function automatic logic signed [31:0] getInReady(input bit nz);
    return nz ? {31'd0, if_nz.in_ready} : {31'd0, if_sz.in_ready};
  endfunction

  function automatic logic signed [31:0] getBusy(input bit nz);
    return nz ? {31'd0, if_nz.busy} : {31'd0, if_sz.busy};
  endfunction

  function automatic logic signed [31:0] getResult(input bit nz);
    return nz ? 32'($signed(if_nz.out_result)) : 32'($signed(if_sz.out_result));
  endfunction

  function automatic logic signed [31:0] getCycles(input bit nz);
    return nz ? {28'd0, if_nz.out_cycles} : {28'd0, if_sz.out_cycles};
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic applyStimulus(input bit nz, input logic v, input int a, input int w);
    if (nz) begin
      if_nz.in_valid = v;
      if_nz.act      = 8'(a);
      if_nz.weight   = 8'(w);
    end else begin
      if_sz.in_valid = v;
      if_sz.act      = 8'(a);
      if_sz.weight   = 8'(w);
    end
  endtask

  task automatic setReady(input bit nz, input logic r);
    if (nz) if_nz.out_ready = r;
    else    if_sz.out_ready = r;
  endtask

  // Full transaction: handshake in, bounded wait for out_valid, check, drain.
  task automatic doOp(input bit nz, input int a, input int w, input string tag);
    int lat;
    int expLat;
    int expRes;
    logic [7:0] wb;
    wb     = 8'(w);
    expRes = a * w;
    expLat = nz ? 8 : $countones(wb);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, getInReady(nz), 1);
    applyStimulus(nz, 1'b1, a, w);
    @(negedge clk);
    applyStimulus(nz, 1'b0, 0, 0);
    lat = 0;
    while (getValid(nz) !== 1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_result"}, getResult(nz), expRes);
    checkOutput({tag, "_cycles"}, getCycles(nz), expLat);
    setReady(nz, 1'b1);
    @(negedge clk);
    setReady(nz, 1'b0);
    checkOutput({tag, "_idle_busy"}, getBusy(nz), 0);
  endtask

  initial begin
    int lat;
    nTests = 0;
    nFail  = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    setReady(1'b0, 1'b0);
    setReady(1'b1, 1'b0);

    // Reset state
    #12;
    checkOutput("rst_out_valid", getValid(0), 0);
    checkOutput("rst_in_ready", getInReady(0), 1);
    checkOutput("rst_busy", getBusy(0), 0);
    checkOutput("rst_result", getResult(0), 0);
    checkOutput("rst_cycles", getCycles(0), 0);
    checkOutput("rst_nz_in_ready", getInReady(1), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed products
    doOp(0, 5, 3, "t1_5x3");
    doOp(0, -128, -128, "t2_min_sq");
    doOp(1, -128, -128, "t2_min_sq_nz");
    doOp(0, 77, 0, "t3_zero_sz");
    doOp(1, 77, 0, "t3_zero_nz");
    doOp(0, -3, -1, "t4_m3xm1_sz");
    doOp(1, -3, -1, "t4_m3xm1_nz");
    doOp(0, 127, -128, "t4_127xm128");
    doOp(1, 127, -128, "t4_127xm128_nz");
    doOp(1, 5, 3, "t1_5x3_nz");

    // Backpressure: result held, new operands ignored while in DONE
    @(negedge clk);
    applyStimulus(0, 1'b1, 6, 5);
    @(negedge clk);
    applyStimulus(0, 1'b0, 0, 0);
    lat = 0;
    while (getValid(0) !== 1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp_latency", lat, 2);
    applyStimulus(0, 1'b1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", getValid(0), 1);
      checkOutput("bp_result", getResult(0), 30);
      checkOutput("bp_cycles", getCycles(0), 2);
      checkOutput("bp_in_ready", getInReady(0), 0);
    end
    applyStimulus(0, 1'b0, 0, 0);
    setReady(0, 1'b1);
    @(negedge clk);
    setReady(0, 1'b0);
    checkOutput("bp_release_valid", getValid(0), 0);
    checkOutput("bp_release_in_ready", getInReady(0), 1);
    doOp(0, -7, 9, "bp_next");

    // Asynchronous reset mid-RUN
    @(negedge clk);
    applyStimulus(0, 1'b1, 9, 8'h55);
    @(negedge clk);
    applyStimulus(0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("mid_run_busy", getBusy(0), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", getValid(0), 0);
    checkOutput("arst_busy", getBusy(0), 0);
    checkOutput("arst_in_ready", getInReady(0), 1);
    checkOutput("arst_acc", getResult(0), 0);
    checkOutput("arst_cycles", getCycles(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    doOp(0, 2, 6, "post_rst_2x6");

    // Random operands against a signed multiply
    for (int i = 0; i < 150; i++) begin
      doOp(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, "rand_sz");
      doOp(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, "rand_nz");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
